// File: rtl/hilo_div_unit.sv
// hilo_div_unit: multi-cycle restoring divider feeding the HI/LO register pair.
// Produces one quotient bit per cycle, writes LO=quotient and HI=remainder, and
// raises stall when the pipeline needs HI/LO or the divider while a divide runs.
module hilo_div_unit #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             mf_read,
    input  logic             lo_or_hi,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_data
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } divState_t;

    divState_t        stateReg;
    logic [CW-1:0]    countReg;
    logic [WIDTH-1:0] dvdReg;      // dividend magnitude, consumed MSB first
    logic [WIDTH-1:0] dvsReg;      // divisor magnitude
    logic [WIDTH-1:0] quoReg;      // quotient magnitude being assembled
    logic [WIDTH:0]   remReg;      // partial remainder, one extra bit for the borrow
    logic             quoNegReg;
    logic             remNegReg;
    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;
    logic             doneReg;

    logic             dividendNeg;
    logic             divisorNeg;
    logic [WIDTH-1:0] dividendAbs;
    logic [WIDTH-1:0] divisorAbs;
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   remTrial;
    logic             noBorrow;
    logic [WIDTH-1:0] remLow;
    logic [WIDTH-1:0] quoFixed;
    logic [WIDTH-1:0] remFixed;

    // Operand magnitudes; in unsigned mode the raw values pass straight through.
    // The magnitude of the most negative value still fits as an unsigned number.
    always_comb begin
        dividendNeg = SIGNED && dividend[WIDTH-1];
        divisorNeg  = SIGNED && divisor[WIDTH-1];
        dividendAbs = dividendNeg ? (~dividend + 1'b1) : dividend;
        divisorAbs  = divisorNeg  ? (~divisor + 1'b1)  : divisor;
    end

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        remShift = {remReg[WIDTH-1:0], dvdReg[WIDTH-1]};
        remTrial = remShift - {1'b0, dvsReg};
        noBorrow = ~remTrial[WIDTH];
    end

    // Sign correction applied on the way into HI/LO.
    always_comb begin
        remLow   = remReg[WIDTH-1:0];
        quoFixed = quoNegReg ? (~quoReg + 1'b1) : quoReg;
        remFixed = remNegReg ? (~remLow + 1'b1) : remLow;
    end

    // Divider sequencer and HI/LO registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateReg  <= IDLE;
            countReg  <= '0;
            dvdReg    <= '0;
            dvsReg    <= '0;
            quoReg    <= '0;
            remReg    <= '0;
            quoNegReg <= 1'b0;
            remNegReg <= 1'b0;
            hiReg     <= '0;
            loReg     <= '0;
            doneReg   <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (div_start) begin
                        remNegReg <= dividendNeg;
                        dvdReg    <= dividendAbs;
                        dvsReg    <= divisorAbs;
                        countReg  <= CW'(WIDTH - 1);
                        if (divisor == '0) begin
                            // Divide by zero: all-ones quotient, remainder is
                            // the dividend itself (magnitude plus its own sign).
                            quoReg    <= '1;
                            remReg    <= {1'b0, dividendAbs};
                            quoNegReg <= 1'b0;
                            stateReg  <= FIX;
                        end else begin
                            quoReg    <= '0;
                            remReg    <= '0;
                            quoNegReg <= dividendNeg ^ divisorNeg;
                            stateReg  <= RUN;
                        end
                    end
                end
                RUN: begin
                    dvdReg <= {dvdReg[WIDTH-2:0], 1'b0};
                    remReg <= noBorrow ? remTrial : remShift;
                    quoReg <= {quoReg[WIDTH-2:0], noBorrow};
                    if (countReg == '0) begin
                        stateReg <= FIX;
                    end else begin
                        countReg <= countReg - 1'b1;
                    end
                end
                FIX: begin
                    loReg    <= quoFixed;
                    hiReg    <= remFixed;
                    doneReg  <= 1'b1;
                    stateReg <= IDLE;
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

    // Status, stall and the mfhi/mflo read mux.
    always_comb begin
        busy    = (stateReg == RUN) || (stateReg == FIX);
        stall   = busy && (div_start || mf_read);
        done    = doneReg;
        hi      = hiReg;
        lo      = loReg;
        mf_data = lo_or_hi ? loReg : hiReg;
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
// tb_hilo_div_unit: directed checks of the HI/LO divider in signed and
// unsigned builds, sharing one stimulus stream.
module tb_hilo_div_unit;

    logic        clock;
    logic        reset;
    logic        divStart;
    logic [31:0] dividendIn;
    logic [31:0] divisorIn;
    logic        mfRead;
    logic        loOrHi;

    logic        sStall, sBusy, sDone;
    logic [31:0] sHi, sLo, sMf;
    logic        uStall, uBusy, uDone;
    logic [31:0] uHi, uLo, uMf;

    int checks = 0;
    int errors = 0;

    hilo_div_unit #(.WIDTH(32), .SIGNED(1'b1)) dutSigned (
        .clock(clock), .reset(reset), .div_start(divStart),
        .dividend(dividendIn), .divisor(divisorIn),
        .mf_read(mfRead), .lo_or_hi(loOrHi),
        .stall(sStall), .busy(sBusy), .done(sDone),
        .hi(sHi), .lo(sLo), .mf_data(sMf)
    );

    hilo_div_unit #(.WIDTH(32), .SIGNED(1'b0)) dutUnsigned (
        .clock(clock), .reset(reset), .div_start(divStart),
        .dividend(dividendIn), .divisor(divisorIn),
        .mf_read(mfRead), .lo_or_hi(loOrHi),
        .stall(uStall), .busy(uBusy), .done(uDone),
        .hi(uHi), .lo(uLo), .mf_data(uMf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-22s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Issue a start, then wait (bounded) for the selected instance's done.
    // edges counts the start edge as edge 1.
    task automatic runDiv(input bit useUnsigned, input logic [31:0] a,
                          input logic [31:0] b, output int edges);
        bit got;
        divStart   = 1'b1;
        dividendIn = a;
        divisorIn  = b;
        tick();
        divStart = 1'b0;
        edges = 1;
        got   = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            edges++;
            if (useUnsigned ? uDone : sDone) got = 1'b1;
        end
        check("done_within_bound", 32'(got), 32'd1);
    endtask

    initial begin
        int edges;
        int doneSeen;

        reset      = 1'b1;
        divStart   = 1'b0;
        dividendIn = '0;
        divisorIn  = '0;
        mfRead     = 1'b0;
        loOrHi     = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(sBusy), 32'd0);
        check("rst_done", 32'(sDone), 32'd0);
        check("rst_hi", sHi, 32'd0);
        check("rst_lo", sLo, 32'd0);
        check("rst_stall", 32'(sStall), 32'd0);
        reset = 1'b0;
        tick();

        // Reset 10 edges into a 100/7 divide abandons it.
        divStart   = 1'b1;
        dividendIn = 32'd100;
        divisorIn  = 32'd7;
        tick();
        divStart = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("midrun_busy", 32'(sBusy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(sBusy), 32'd0);
        check("abort_hi", sHi, 32'd0);
        check("abort_lo", sLo, 32'd0);
        tick();
        reset    = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sDone) doneSeen++;
        end
        check("abort_no_done", 32'(doneSeen), 32'd0);
        check("abort_lo_held", sLo, 32'd0);

        // Signed 100/7 with an mflo pending during the run.
        divStart   = 1'b1;
        dividendIn = 32'd100;
        divisorIn  = 32'd7;
        tick();
        divStart = 1'b0;
        check("run_busy", 32'(sBusy), 32'd1);
        tick();
        mfRead = 1'b1;
        loOrHi = 1'b1;
        #1;
        check("mf_stall_run", 32'(sStall), 32'd1);
        for (int i = 0; i < 31; i++) tick();
        // 33 edges so far: result not yet written.
        check("pre_fix_done", 32'(sDone), 32'd0);
        check("pre_fix_lo", sLo, 32'd0);
        check("pre_fix_stall", 32'(sStall), 32'd1);
        tick();
        check("div100_7_done", 32'(sDone), 32'd1);
        check("div100_7_lo", sLo, 32'd14);
        check("div100_7_hi", sHi, 32'd2);
        check("div100_7_busy", 32'(sBusy), 32'd0);
        check("mf_stall_done", 32'(sStall), 32'd0);
        check("mf_data_lo", sMf, 32'd14);
        loOrHi = 1'b0;
        #1;
        check("mf_data_hi", sMf, 32'd2);
        mfRead = 1'b0;
        tick();
        check("done_one_cycle", 32'(sDone), 32'd0);

        // Signed operand sign combinations.
        runDiv(1'b0, 32'hFFFF_FFF9, 32'd2, edges);
        check("neg7_2_latency", 32'(edges), 32'd34);
        check("neg7_2_lo", sLo, 32'hFFFF_FFFD);
        check("neg7_2_hi", sHi, 32'hFFFF_FFFF);
        tick();
        runDiv(1'b0, 32'd7, 32'hFFFF_FFFE, edges);
        check("7_neg2_lo", sLo, 32'hFFFF_FFFD);
        check("7_neg2_hi", sHi, 32'd1);
        tick();
        runDiv(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, edges);
        check("min_neg1_lo", sLo, 32'h8000_0000);
        check("min_neg1_hi", sHi, 32'd0);
        tick();

        // Divide by zero takes two edges.
        divStart   = 1'b1;
        dividendIn = 32'd55;
        divisorIn  = 32'd0;
        tick();
        divStart = 1'b0;
        check("dbz_busy", 32'(sBusy), 32'd1);
        check("dbz_early_done", 32'(sDone), 32'd0);
        tick();
        check("dbz_done", 32'(sDone), 32'd1);
        check("dbz_lo", sLo, 32'hFFFF_FFFF);
        check("dbz_hi", sHi, 32'd55);
        check("dbz_busy_end", 32'(sBusy), 32'd0);
        tick();

        // Unsigned divide, then a new start on the done cycle.
        runDiv(1'b1, 32'hFFFF_FFFF, 32'd16, edges);
        check("u_latency", 32'(edges), 32'd34);
        check("u_lo", uLo, 32'h0FFF_FFFF);
        check("u_hi", uHi, 32'd15);
        runDiv(1'b1, 32'd100, 32'd7, edges);
        check("b2b_latency", 32'(edges), 32'd34);
        check("b2b_lo", uLo, 32'd14);
        check("b2b_hi", uHi, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
